multicycle_cpu_core: RTL and testbench

- Parametrised multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB state machine with a real execute path.
- Contains an internal register file, an ALU with Z/C flags, and branch/halt logic.
- Talks to a word-addressed memory over a req/ack handshake that tolerates variable latency.
- Top-level compute block between the memory model and the testbench.

---
 rtl/multicycle_cpu_core.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer, register file, Z/C ALU,
// branch/halt logic and a req/ack memory port that tolerates variable latency.
module multicycle_cpu_core #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       REG_CNT  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int unsigned RAW = $clog2(REG_CNT);

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_LDI = 5'd6;
    localparam logic [4:0] OP_LD  = 5'd7;
    localparam logic [4:0] OP_ST  = 5'd8;
    localparam logic [4:0] OP_JMP = 5'd9;
    localparam logic [4:0] OP_BZ  = 5'd10;
    localparam logic [4:0] OP_HLT = 5'd11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e r_state;
    state_e w_next_state;

    logic [ADDR_W-1:0] r_pc;
    logic [4:0]        r_op;
    logic [RAW-1:0]    r_rd;
    logic [RAW-1:0]    r_rs;
    logic [ADDR_W-1:0] r_imm;
    logic [DATA_W-1:0] r_rd_val;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_result;
    logic              r_z;
    logic              r_c;
    logic              r_illegal;
    logic [DATA_W-1:0] r_regs [REG_CNT];

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_flag_op;
    logic              w_wb_op;

    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // The top bit of the widened difference is the borrow (rd < rs unsigned).
    always_comb begin
        w_sum     = {1'b0, r_rd_val} + {1'b0, r_rs_val};
        w_diff    = {1'b0, r_rd_val} - {1'b0, r_rs_val};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_alu_c   = w_diff[DATA_W];
            end
            OP_AND:  w_alu_res = r_rd_val & r_rs_val;
            OP_OR:   w_alu_res = r_rd_val | r_rs_val;
            OP_XOR:  w_alu_res = r_rd_val ^ r_rs_val;
            OP_LDI:  w_alu_res = DATA_W'(r_imm);
            default: w_alu_res = '0;
        endcase
    end

    assign w_flag_op = (r_op >= OP_ADD) && (r_op <= OP_XOR);
    assign w_wb_op   = w_flag_op || (r_op == OP_LDI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = r_pc;
                if (mem_ack) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_wb_op) begin
                    w_next_state = S_WB;
                end else if ((r_op == OP_LD) || (r_op == OP_ST)) begin
                    w_next_state = S_MEM;
                end else if ((r_op == OP_NOP) || (r_op == OP_JMP) || (r_op == OP_BZ)) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_addr = r_imm;
                if (r_op == OP_ST) begin
                    w_we    = 1'b1;
                    w_wdata = r_rd_val;
                end
                if (mem_ack) begin
                    w_next_state = (r_op == OP_LD) ? S_WB : S_FETCH;
                end
            end
            S_WB:    w_next_state = S_FETCH;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_op      <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_imm     <= '0;
            r_rd_val  <= '0;
            r_rs_val  <= '0;
            r_result  <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_illegal <= 1'b0;
            for (int unsigned i = 0; i < REG_CNT; i++) begin
                r_regs[RAW'(i)] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_op  <= mem_rdata[DATA_W-1 -: 5];
                        r_rd  <= mem_rdata[DATA_W-6 -: RAW];
                        r_rs  <= mem_rdata[DATA_W-6-RAW -: RAW];
                        r_imm <= mem_rdata[ADDR_W-1:0];
                        r_pc  <= r_pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    r_rd_val <= r_regs[r_rd];
                    r_rs_val <= r_regs[r_rs];
                end
                S_EXEC: begin
                    if (w_wb_op) begin
                        r_result <= w_alu_res;
                    end
                    if (w_flag_op) begin
                        r_z <= (w_alu_res == '0);
                        r_c <= w_alu_c;
                    end
                    if ((r_op == OP_JMP) || ((r_op == OP_BZ) && r_z)) begin
                        r_pc <= r_imm;
                    end
                    if (r_op > OP_HLT) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ack && (r_op == OP_LD)) begin
                        r_result <= mem_rdata;
                    end
                end
                S_WB:    r_regs[r_rd] <= r_result;
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so a stale state cannot leak a request.
    assign mem_req   = w_req & ~reset;
    assign mem_we    = w_we & ~reset;
    assign mem_addr  = reset ? '0 : w_addr;
    assign mem_wdata = reset ? '0 : w_wdata;
    assign halted    = (r_state == S_HALT) && !reset;
    assign illegal   = r_illegal && !reset;
    assign pc_dbg    = r_pc;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Bench for multicycle_cpu_core: ISA-level reference model, ALU vector table,
// variable-latency memory responder and hand-written corner-case sequences.
module tb_multicycle_cpu_core;

    localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4, OP_XOR = 5;
    localparam int OP_LDI = 6, OP_LD = 7, OP_ST = 8, OP_JMP = 9, OP_BZ = 10, OP_HLT = 11;
    localparam int OP_BAD = 31;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack, halted, illegal;
    logic [15:0] mem_addr, pc_dbg;
    logic [31:0] mem_wdata, mem_rdata;

    multicycle_cpu_core #(
        .DATA_W  (32),
        .ADDR_W  (16),
        .REG_CNT (8),
        .RESET_PC(16'h0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .halted   (halted),
        .illegal  (illegal),
        .pc_dbg   (pc_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Memory responder: wait_mode 0 = zero wait, 1 = three waits, 2 = random 0..3 waits.
    logic [31:0] mem [0:511];
    int          wcnt = 0;
    int          cur_wait = 0;
    int          wait_mode = 0;
    bit          block_we = 1'b0;
    bit          force_ack = 1'b0;

    assign mem_ack   = force_ack | (mem_req && !(block_we && mem_we) && (wcnt >= cur_wait));
    assign mem_rdata = mem[mem_addr[8:0]];

    function automatic int draw_wait(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr[8:0]] = mem_wdata;
            wcnt     <= 0;
            cur_wait <= draw_wait(wait_mode);
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt     <= 0;
            cur_wait <= draw_wait(wait_mode);
        end
    end

    // Bus monitor: wait cycles, stability during waits, read address trace.
    int          wait_cycles = 0;
    int          unstable = 0;
    int          read_q[$];
    bit          prev_wait = 1'b0;
    logic [15:0] prev_addr;
    logic        prev_we;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        if (reset) begin
            prev_wait = 1'b0;
        end else begin
            if (mem_req && !mem_ack) wait_cycles++;
            if (prev_wait && (!mem_req || mem_addr != prev_addr || mem_we != prev_we ||
                              mem_wdata != prev_wdata)) unstable++;
            if (mem_req && mem_ack && !mem_we) read_q.push_back(int'(mem_addr));
            prev_wait  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int imm);
        return (32'(op) << 27) | (32'(rd) << 24) | (32'(rs) << 21) | 32'(imm & 'hFFFF);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    // Reset, check the quiet reset outputs, release and count cycles until halted.
    task automatic run_prog(input int mode, output int cycles);
        bit done;
        @(negedge clk);
        reset = 1'b1;
        wait_mode = mode;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", pc_dbg, 0);
        wait_cycles = 0;
        unstable = 0;
        read_q.delete();
        reset = 1'b0;
        cycles = 0;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (halted) done = 1'b1;
        end
        chk("halt_reached", done, 1);
    endtask

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          z;
        bit          c;
    } vec_t;

    vec_t vt[9];

    logic [31:0] mm [0:511];
    int unsigned mr [8];

    initial begin
        int cyc, exp_cyc, seen, reqs;

        vt[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vt[1] = '{OP_ADD, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0};
        vt[2] = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vt[3] = '{OP_SUB, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};
        vt[4] = '{OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
        vt[5] = '{OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
        vt[6] = '{OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0};
        vt[7] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vt[8] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0};

        // Basic program, zero-wait then three waits per request.
        for (int m = 0; m < 2; m++) begin
            clear_mem();
            mem[0] = enc(OP_LDI, 1, 0, 5);
            mem[1] = enc(OP_LDI, 2, 0, 7);
            mem[2] = enc(OP_ADD, 1, 2, 0);
            mem[3] = enc(OP_ST, 1, 0, 'h20);
            mem[4] = enc(OP_HLT, 0, 0, 0);
            run_prog(m, cyc);
            chk("basic_mem20", mem['h20], 32'd12);
            chk("basic_illegal", illegal, 0);
            chk("basic_cycles", cyc, (m == 0) ? 19 : 19 + 3 * 6);
            chk("basic_stable", unstable, 0);
        end

        // ALU vectors: Z is observed through a BZ into an illegal word.
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            mem['h90] = vt[v].a;
            mem['h91] = vt[v].b;
            mem[0] = enc(OP_LD, 1, 0, 'h90);
            mem[1] = enc(OP_LD, 2, 0, 'h91);
            mem[2] = enc(vt[v].op, 1, 2, 0);
            mem[3] = enc(OP_ST, 1, 0, 'h92);
            mem[4] = enc(OP_BZ, 0, 0, 6);
            mem[5] = enc(OP_HLT, 0, 0, 0);
            mem[6] = enc(OP_BAD, 0, 0, 0);
            run_prog(0, cyc);
            chk("vec_res", mem['h92], vt[v].res);
            chk("vec_z", illegal, vt[v].z);
            chk("vec_c", dut.r_c, vt[v].c);
            chk("vec_cycles", cyc, 24);
        end

        // BZ taken after SUB r3,r3.
        clear_mem();
        mem[0] = enc(OP_LDI, 3, 0, 9);
        mem[1] = enc(OP_SUB, 3, 3, 0);
        mem[2] = enc(OP_BZ, 0, 0, 'h40);
        mem[3] = enc(OP_BAD, 0, 0, 0);
        mem['h40] = enc(OP_HLT, 0, 0, 0);
        run_prog(0, cyc);
        chk("bz_taken_addr", (read_q.size() > 3) ? read_q[3] : -1, 'h40);
        chk("bz_taken_illegal", illegal, 0);
        chk("bz_taken_c", dut.r_c, 0);
        chk("bz_taken_cycles", cyc, 14);

        // BZ not taken after SUB r3,r0 with r3 = 1.
        clear_mem();
        mem[0] = enc(OP_LDI, 3, 0, 1);
        mem[1] = enc(OP_SUB, 3, 0, 0);
        mem[2] = enc(OP_BZ, 0, 0, 'h40);
        mem[3] = enc(OP_HLT, 0, 0, 0);
        mem['h40] = enc(OP_BAD, 0, 0, 0);
        run_prog(0, cyc);
        chk("bz_nt_addr", (read_q.size() > 3) ? read_q[3] : -1, 3);
        chk("bz_nt_illegal", illegal, 0);

        // LD then ST of the same register.
        clear_mem();
        mem['h10] = 32'hDEAD_BEEF;
        mem[0] = enc(OP_LD, 4, 0, 'h10);
        mem[1] = enc(OP_ST, 4, 0, 'h11);
        mem[2] = enc(OP_HLT, 0, 0, 0);
        run_prog(0, cyc);
        chk("ldst_mem11", mem['h11], 32'hDEAD_BEEF);
        chk("ldst_cycles", cyc, 12);

        // Illegal opcode 31 halts and stays quiet on the bus.
        clear_mem();
        mem[0] = enc(OP_LDI, 1, 0, 1);
        mem[1] = enc(OP_BAD, 0, 0, 0);
        run_prog(0, cyc);
        chk("bad_illegal", illegal, 1);
        chk("bad_cycles", cyc, 7);
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        chk("bad_no_req", reqs, 0);
        chk("bad_still_halted", halted, 1);

        // Reset during a stalled ST, with an ack arriving while reset is held.
        clear_mem();
        mem['h30] = 32'h0000_1234;
        mem[0] = enc(OP_LDI, 1, 0, 'h55);
        mem[1] = enc(OP_ST, 1, 0, 'h30);
        mem[2] = enc(OP_HLT, 0, 0, 0);
        block_we = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wait_mode = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            @(negedge clk);
            if (mem_req && mem_we) seen = 1;
        end
        chk("mid_st_reached", seen, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", mem_req, 0);
        @(negedge clk);
        force_ack = 1'b0;
        chk("mid_no_write", mem['h30], 32'h0000_1234);
        read_q.delete();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_refetch", (read_q.size() > 0) ? read_q[0] : -1, 0);
        block_we = 1'b0;

        // Random programs checked against an ISA-level model.
        for (int t = 0; t < 4; t++) begin
            int mode;
            mode = (t == 0) ? 0 : ((t == 1) ? 1 : 2);
            clear_mem();
            for (int i = 0; i < 24; i++) begin
                int sel, op, imm;
                sel = int'($urandom_range(0, 10));
                op = (sel == 9) ? OP_JMP : ((sel == 10) ? OP_BZ : sel);
                imm = int'($urandom_range(0, 65535));
                if (op == OP_LD || op == OP_ST) imm = 'h80 + int'($urandom_range(0, 15));
                if (op == OP_JMP || op == OP_BZ) begin
                    imm = i + 1 + int'($urandom_range(0, 3));
                    if (imm > 24) imm = 24;
                end
                mem[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
            end
            for (int k = 0; k < 8; k++) mem[24 + k] = enc(OP_ST, k, 0, 'h100 + k);
            mem[32] = enc(OP_HLT, 0, 0, 0);
            for (int j = 0; j < 16; j++) mem['h80 + j] = $urandom;
            for (int i = 0; i < 512; i++) mm[i] = mem[i];

            begin
                int unsigned pc, op, rd, rs, imm, a, b;
                bit mz, mc, stop;
                longint s;
                for (int k = 0; k < 8; k++) mr[k] = 0;
                mz = 0; mc = 0; pc = 0; exp_cyc = 0; stop = 0;
                for (int step = 0; step < 200 && !stop; step++) begin
                    op = mm[pc] >> 27;
                    rd = (mm[pc] >> 24) & 7;
                    rs = (mm[pc] >> 21) & 7;
                    imm = mm[pc] & 'hFFFF;
                    a = mr[rd];
                    b = mr[rs];
                    pc = pc + 1;
                    case (op)
                        OP_ADD: begin
                            s = longint'(a) + longint'(b);
                            mr[rd] = a + b; mc = (s > 64'hFFFF_FFFF); mz = (mr[rd] == 0); exp_cyc += 4;
                        end
                        OP_SUB: begin mr[rd] = a - b; mc = (a < b); mz = (mr[rd] == 0); exp_cyc += 4; end
                        OP_AND: begin mr[rd] = a & b; mc = 0; mz = (mr[rd] == 0); exp_cyc += 4; end
                        OP_OR:  begin mr[rd] = a | b; mc = 0; mz = (mr[rd] == 0); exp_cyc += 4; end
                        OP_XOR: begin mr[rd] = a ^ b; mc = 0; mz = (mr[rd] == 0); exp_cyc += 4; end
                        OP_LDI: begin mr[rd] = imm; exp_cyc += 4; end
                        OP_LD:  begin mr[rd] = mm[imm]; exp_cyc += 5; end
                        OP_ST:  begin mm[imm] = a; exp_cyc += 4; end
                        OP_JMP: begin pc = imm; exp_cyc += 3; end
                        OP_BZ:  begin if (mz) pc = imm; exp_cyc += 3; end
                        OP_NOP: exp_cyc += 3;
                        default: begin exp_cyc += 3; stop = 1; end
                    endcase
                end
            end

            run_prog(mode, cyc);
            chk("rnd_illegal", illegal, 0);
            chk("rnd_cycles", cyc, exp_cyc + wait_cycles);
            chk("rnd_stable", unstable, 0);
            for (int k = 0; k < 8; k++) chk("rnd_reg", mem['h100 + k], mm['h100 + k]);
            for (int j = 0; j < 16; j++) chk("rnd_data", mem['h80 + j], mm['h80 + j]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
